// File: rtl/rd_lead_pkg.sv
// Shared definitions for the packet read leader and its descriptor writer:
// descriptor field layout, header byte format and FSM encoding.
package rd_lead_pkg;

    localparam int INFO_W     = 20;
    localparam int LEN_MSB    = 19;
    localparam int LEN_LSB    = 8;
    localparam int PRI_MSB    = 7;
    localparam int PRI_LSB    = 4;
    localparam int DEST_MSB   = 3;
    localparam int DEST_LSB   = 0;
    localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [3:0]       pri;
        logic [3:0]       dest;
    } info_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAY  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic info_t unpack_info(input logic [INFO_W-1:0] raw);
        info_t i;
        i.len  = raw[LEN_MSB:LEN_LSB];
        i.pri  = raw[PRI_MSB:PRI_LSB];
        i.dest = raw[DEST_MSB:DEST_LSB];
        return i;
    endfunction

    // Header byte: bit 7 reserved zero, 3-bit priority, 4-bit destination port.
    function automatic logic [7:0] hdr_byte(input info_t i);
        return {1'b0, i.pri[2:0], i.dest};
    endfunction

endpackage

// File: rtl/rd_lead_if.sv
// Descriptor, upstream byte FIFO and output stream signals of rd_lead.
interface rd_lead_if import rd_lead_pkg::*;;

    logic [INFO_W-1:0] data_info;
    logic              data_info_vld;
    logic              data_ren;
    logic [7:0]        data_in;
    logic              tx_rdy;
    logic              rd_sop;
    logic              rd_eop;
    logic              rd_vld;
    logic [7:0]        rd_data;
    logic              info_full;
    logic              info_ovf;
    logic              busy;

    modport slave (
        input  data_info, data_info_vld, data_in, tx_rdy,
        output data_ren, rd_sop, rd_eop, rd_vld, rd_data, info_full, info_ovf, busy
    );

    modport master (
        output data_info, data_info_vld, data_in, tx_rdy,
        input  data_ren, rd_sop, rd_eop, rd_vld, rd_data, info_full, info_ovf, busy
    );

endinterface

// File: rtl/rd_lead_info_fifo.sv
// 4-deep first-word-fall-through descriptor queue; a push into a full queue
// is accepted only when a pop frees a slot in the same cycle.
module info_fifo import rd_lead_pkg::*; (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  info_t din,
    output info_t dout,
    output logic  empty,
    output logic  full,
    output logic  drop
);

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    info_t      mem [FIFO_DEPTH];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] cnt, cnt_d;
    logic       do_push, do_pop;

    assign do_pop  = pop && (cnt != 3'd0);
    assign do_push = push && ((cnt != DEPTH) || do_pop);
    assign drop    = push && !do_push;
    assign cnt_d   = cnt + 3'(do_push) - 3'(do_pop);
    assign empty   = (cnt == 3'd0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            cnt    <= 3'd0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
            cnt  <= cnt_d;
            full <= (cnt_d == DEPTH);
        end
    end

endmodule

// File: rtl/rd_lead.sv
// Pops packet descriptors, reads len payload bytes from the upstream FIFO and
// emits a header byte followed by the payload as one contiguous sop..eop burst.
module rd_lead import rd_lead_pkg::*; (
    input  logic       sys_clk,
    input  logic       sys_rst,
    rd_lead_if.slave   bus
);

    state_t           state_q, state_d;
    info_t            info_in, fifo_dout;
    logic             fifo_empty, fifo_full, fifo_drop, pop;
    logic [LEN_W-1:0] rem_q;
    logic [7:0]       hdr_q;
    logic             ren, ren_last, ren_d1_q, last_d1_q;
    logic [7:0]       rd_data_q;
    logic             rd_vld_q, rd_sop_q, rd_eop_q, ovf_q;

    assign info_in = unpack_info(bus.data_info);

    info_fifo u_info_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (bus.data_info_vld),
        .pop   (pop),
        .din   (info_in),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop  (fifo_drop)
    );

    // rem_q counts reads still to issue; reads start in LOAD so the upstream
    // data lines up directly behind the registered header byte.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        ren      = 1'b0;
        ren_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && bus.tx_rdy) begin
                    pop     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ren      = (rem_q != '0);
                ren_last = (rem_q == LEN_W'(1));
                state_d  = (rem_q != '0) ? ST_PAY : ST_GAP;
            end
            ST_PAY: begin
                ren      = (rem_q != '0);
                ren_last = (rem_q == LEN_W'(1));
                if (last_d1_q) state_d = ST_GAP;
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            hdr_q     <= 8'd0;
            ren_d1_q  <= 1'b0;
            last_d1_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ren_d1_q  <= ren;
            last_d1_q <= ren_last;
            ovf_q     <= ovf_q | fifo_drop;
            if (pop) begin
                rem_q <= fifo_dout.len;
                hdr_q <= hdr_byte(fifo_dout);
            end else if (ren) begin
                rem_q <= rem_q - LEN_W'(1);
            end
        end
    end

    // Output register: header from LOAD, then each byte the cycle after its read.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_data_q <= 8'd0;
            rd_vld_q  <= 1'b0;
            rd_sop_q  <= 1'b0;
            rd_eop_q  <= 1'b0;
        end else begin
            rd_vld_q <= 1'b0;
            rd_sop_q <= 1'b0;
            rd_eop_q <= 1'b0;
            if (state_q == ST_LOAD) begin
                rd_data_q <= hdr_q;
                rd_vld_q  <= 1'b1;
                rd_sop_q  <= 1'b1;
                rd_eop_q  <= (rem_q == '0);
            end else if (ren_d1_q) begin
                rd_data_q <= bus.data_in;
                rd_vld_q  <= 1'b1;
                rd_eop_q  <= last_d1_q;
            end
        end
    end

    assign bus.data_ren  = ren;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_vld    = rd_vld_q;
    assign bus.rd_sop    = rd_sop_q;
    assign bus.rd_eop    = rd_eop_q;
    assign bus.info_full = fifo_full;
    assign bus.info_ovf  = ovf_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
